// File: rtl/hdlc_rx_drain.sv
// Drains completed frames out of the Hdlc Rx buffer onto a valid/ready byte stream.
// Optional macro HDLC_RX_DRAIN_FCS_EN: CFG writes Rx_FCSen before entering IDLE.
module hdlc_rx_drain #(
  parameter int unsigned MAX_LEN = 126
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx_Ready,
  output logic [2:0] Address,
  output logic       WriteEnable,
  output logic       ReadEnable,
  output logic [7:0] WrData,
  input  logic [7:0] RdData,
  output logic [7:0] Frm_Data,
  output logic       Frm_Valid,
  input  logic       Frm_Ready,
  output logic       Frm_Last,
  output logic       Drain_Busy,
  output logic [7:0] Err_Count
);

  localparam logic [2:0] RegSc   = 3'd2;
  localparam logic [2:0] RegBuff = 3'd3;
  localparam logic [2:0] RegLen  = 3'd4;

  typedef enum logic [3:0] {
    StCfg,
    StIdle,
    StRdSc,
    StWaitSc,
    StRdLen,
    StWaitLen,
    StRdByte,
    StWaitByte,
    StHold,
    StDrop,
    StWaitClr
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] addr_q, addr_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;
  logic       busy_q, busy_d;
  logic [7:0] err_q, err_d;
  logic [7:0] rem_q, rem_d;
  logic       go_drop;

  // Strobes and stream outputs are computed from the next state so every output is a flop.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    wdata_d = wdata_q;
    data_d  = data_q;
    last_d  = last_q;
    rem_d   = rem_q;
    err_d   = err_q;
    go_drop = 1'b0;

    unique case (state_q)
      StCfg: begin
        state_d = StIdle;
`ifdef HDLC_RX_DRAIN_FCS_EN
        we_d    = 1'b1;
        addr_d  = RegSc;
        wdata_d = 8'h20;
`endif
      end
      StIdle: begin
        if (Rx_Ready) begin
          state_d = StRdSc;
          re_d    = 1'b1;
          addr_d  = RegSc;
        end
      end
      StRdSc: state_d = StWaitSc;
      StWaitSc: begin
        if (|RdData[4:2]) begin
          go_drop = 1'b1;
        end else begin
          state_d = StRdLen;
          re_d    = 1'b1;
          addr_d  = RegLen;
        end
      end
      StRdLen: state_d = StWaitLen;
      StWaitLen: begin
        rem_d = RdData;
        if (RdData == 8'd0 || {24'd0, RdData} > MAX_LEN) begin
          go_drop = 1'b1;
        end else begin
          state_d = StRdByte;
          re_d    = 1'b1;
          addr_d  = RegBuff;
        end
      end
      StRdByte: state_d = StWaitByte;
      StWaitByte: begin
        data_d  = RdData;
        rem_d   = rem_q - 8'd1;
        last_d  = (rem_q == 8'd1);
        state_d = StHold;
      end
      StHold: begin
        if (Frm_Ready) begin
          if (last_q) begin
            state_d = StWaitClr;
          end else begin
            state_d = StRdByte;
            re_d    = 1'b1;
            addr_d  = RegBuff;
          end
        end
      end
      StDrop: begin
        if (err_q != 8'hFF) begin
          err_d = err_q + 8'd1;
        end
        state_d = StWaitClr;
      end
      StWaitClr: begin
        // Hold off until Hdlc has cleared its flag so the same frame is not read twice.
        if (!Rx_Ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StCfg;
    endcase

    if (go_drop) begin
      state_d = StDrop;
      we_d    = 1'b1;
      addr_d  = RegSc;
      wdata_d = 8'h02;
    end

    valid_d = (state_d == StHold);
    busy_d  = !(state_d inside {StCfg, StIdle});
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= StCfg;
      addr_q  <= 3'd0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      wdata_q <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 8'd0;
      rem_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      re_q    <= re_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rem_q   <= rem_d;
    end
  end

  assign Address     = addr_q;
  assign WriteEnable = we_q;
  assign ReadEnable  = re_q;
  assign WrData      = wdata_q;
  assign Frm_Data    = data_q;
  assign Frm_Valid   = valid_q;
  assign Frm_Last    = last_q;
  assign Drain_Busy  = busy_q;
  assign Err_Count   = err_q;

endmodule

// File: tb/tb_hdlc_rx_drain.sv
// Bench for hdlc_rx_drain: behavioural Hdlc register model, frame vector table and a
// beat scoreboard; honours HDLC_RX_DRAIN_FCS_EN for the CFG write expectation.
module tb_hdlc_rx_drain;

  logic       clk;
  logic       rst_n;
  logic       rx_ready;
  logic [2:0] address;
  logic       write_enable;
  logic       read_enable;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic [7:0] frm_data;
  logic       frm_valid;
  logic       frm_ready;
  logic       frm_last;
  logic       drain_busy;
  logic [7:0] err_count;

  hdlc_rx_drain #(.MAX_LEN(126)) dut (
    .Clk        (clk),
    .Rst        (rst_n),
    .Rx_Ready   (rx_ready),
    .Address    (address),
    .WriteEnable(write_enable),
    .ReadEnable (read_enable),
    .WrData     (wr_data),
    .RdData     (rd_data),
    .Frm_Data   (frm_data),
    .Frm_Valid  (frm_valid),
    .Frm_Ready  (frm_ready),
    .Frm_Last   (frm_last),
    .Drain_Busy (drain_busy),
    .Err_Count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  status;
    logic [7:0]  len;
    logic [31:0] data;   // first four payload bytes, MSB first
    logic        stall;  // toggle Frm_Ready every 2 cycles
    logic        drop;   // expected: frame dropped
    logic [3:0]  tim;    // expected: cycle of first Frm_Valid, or of the drop write
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Hdlc model state
  logic [7:0] mdl_status;
  logic [7:0] mdl_len;
  logic [7:0] mdl_buf[$];
  logic [7:0] next_rd;
  logic       clr_pending;

  // Observations
  logic [8:0] sb[$];
  int         n_reads, n_writes, n_beats, step_no, first_valid, we_step, cyc;
  logic [2:0] last_waddr;
  logic [7:0] last_wdata;
  logic       stall_mode, stalled_prev, held_last;
  logic [7:0] held_data;
  int         err_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] vbyte(input vec_t v, input int i);
    if (i < 4) return v.data[8*(3-i) +: 8];
    return 8'(i * 7 + 3);
  endfunction

  // One clock: Hdlc model and input drive just after the rising edge, checks on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    step_no++;
    cyc++;
    rd_data = next_rd;
    if (clr_pending) begin
      rx_ready    = 1'b0;
      clr_pending = 1'b0;
    end
    if (read_enable) begin
      n_reads++;
      case (address)
        3'd2: next_rd = mdl_status;
        3'd4: next_rd = mdl_len;
        3'd3: begin
          if (mdl_buf.size() != 0) begin
            next_rd = mdl_buf.pop_front();
            if (mdl_buf.size() == 0) clr_pending = 1'b1;
          end else begin
            next_rd = 8'h00;
          end
        end
        default: next_rd = 8'h00;
      endcase
    end
    if (write_enable) begin
      n_writes++;
      we_step    = step_no;
      last_waddr = address;
      last_wdata = wr_data;
      if (address == 3'd2 && wr_data[1]) begin
        mdl_buf.delete();
        clr_pending = 1'b1;
      end
    end
    frm_ready = stall_mode ? cyc[1] : 1'b1;

    @(negedge clk);
    if (read_enable || write_enable) check("strobe_exclusive", 32'(read_enable & write_enable), 0);
    if (frm_valid) begin
      if (first_valid == 0) first_valid = step_no;
      if (stalled_prev) begin
        check("stall_data", 32'(frm_data), 32'(held_data));
        check("stall_last", 32'(frm_last), 32'(held_last));
      end
      held_data = frm_data;
      held_last = frm_last;
      if (frm_ready) begin
        n_beats++;
        check("beat_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) check("beat", 32'({frm_last, frm_data}), 32'(sb.pop_front()));
      end
      stalled_prev = !frm_ready;
    end else begin
      stalled_prev = 1'b0;
    end
  endtask

  task automatic clear_obs();
    n_reads      = 0;
    n_writes     = 0;
    n_beats      = 0;
    step_no      = 0;
    first_valid  = 0;
    we_step      = 0;
    last_waddr   = 3'd0;
    last_wdata   = 8'd0;
    stalled_prev = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    logic done;
    int   exp_reads;
    mdl_status = v.status;
    mdl_len    = v.len;
    mdl_buf.delete();
    for (int i = 0; i < int'(v.len); i++) mdl_buf.push_back(vbyte(v, i));
    if (!v.drop) begin
      for (int i = 0; i < int'(v.len); i++) sb.push_back({i == int'(v.len) - 1, vbyte(v, i)});
    end
    stall_mode = v.stall;
    clear_obs();
    rx_ready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 1000 && !done; k++) begin
      step();
      done = !rx_ready && !drain_busy;
    end
    check("frame_done", 32'(done), 1);
    if (!v.drop) exp_reads = 2 + int'(v.len);
    else exp_reads = ((v.status & 8'h1C) != 8'h00) ? 1 : 2;
    check("reads", n_reads, exp_reads);
    check("writes", n_writes, v.drop ? 1 : 0);
    check("beats", n_beats, v.drop ? 0 : int'(v.len));
    check("sb_empty", sb.size(), 0);
    if (v.drop) begin
      if (err_exp < 255) err_exp++;
      check("drop_write", 32'({last_waddr, last_wdata}), 32'({3'd2, 8'h02}));
      check("drop_cycle", we_step, 32'(v.tim));
    end else begin
      check("first_valid", first_valid, 32'(v.tim));
    end
    check("err_count", 32'(err_count), err_exp);
    sb.delete();
    stall_mode = 1'b0;
    frm_ready  = 1'b1;
  endtask

  vec_t vecs[8];

  initial begin
    vec_t v;
    logic hit;
    vecs[0] = '{8'h01, 8'd4,   32'hA53C00FF, 1'b0, 1'b0, 4'd7};  // clean
    vecs[1] = '{8'h01, 8'd4,   32'hA53C00FF, 1'b1, 1'b0, 4'd7};  // clean, sink stalls
    vecs[2] = '{8'h05, 8'd4,   32'hA53C00FF, 1'b0, 1'b1, 4'd3};  // frame error
    vecs[3] = '{8'h01, 8'd127, 32'h01020304, 1'b0, 1'b1, 4'd5};  // over MAX_LEN
    vecs[4] = '{8'h01, 8'd0,   32'h01020304, 1'b0, 1'b1, 4'd5};  // zero length
    vecs[5] = '{8'h11, 8'd2,   32'h11223344, 1'b0, 1'b1, 4'd3};  // overflow
    vecs[6] = '{8'h01, 8'd1,   32'h5A000000, 1'b0, 1'b0, 4'd7};  // single byte
    vecs[7] = '{8'h01, 8'd126, 32'hDEADBEEF, 1'b0, 1'b0, 4'd7};  // exactly MAX_LEN

    rst_n       = 1'b0;
    rx_ready    = 1'b0;
    frm_ready   = 1'b1;
    rd_data     = 8'h00;
    next_rd     = 8'h00;
    clr_pending = 1'b0;
    stall_mode  = 1'b0;
    cyc         = 0;
    err_exp     = 0;
    clear_obs();
    #2;
    check("rst_address", 32'(address), 0);
    check("rst_we", 32'(write_enable), 0);
    check("rst_re", 32'(read_enable), 0);
    check("rst_wrdata", 32'(wr_data), 0);
    check("rst_frm_data", 32'(frm_data), 0);
    check("rst_frm_valid", 32'(frm_valid), 0);
    check("rst_frm_last", 32'(frm_last), 0);
    check("rst_busy", 32'(drain_busy), 0);
    check("rst_err", 32'(err_count), 0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();

    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    // Abort flood: the drop counter must saturate.
    v = '{8'h09, 8'd3, 32'h0, 1'b0, 1'b1, 4'd3};
    for (int i = 0; i < 256; i++) run_frame(v);
    check("err_saturated", 32'(err_count), 255);

    // Reset asserted during the third HOLD of a 10-byte frame.
    v = '{8'h01, 8'd10, 32'h10203040, 1'b0, 1'b0, 4'd7};
    mdl_status = v.status;
    mdl_len    = v.len;
    mdl_buf.delete();
    for (int i = 0; i < 10; i++) mdl_buf.push_back(vbyte(v, i));
    for (int i = 0; i < 10; i++) sb.push_back({i == 9, vbyte(v, i)});
    clear_obs();
    rx_ready = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      step();
      hit = (n_beats == 3);
    end
    check("third_hold_reached", 32'(hit), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_address", 32'(address), 0);
    check("mid_rst_we", 32'(write_enable), 0);
    check("mid_rst_re", 32'(read_enable), 0);
    check("mid_rst_wrdata", 32'(wr_data), 0);
    check("mid_rst_frm_data", 32'(frm_data), 0);
    check("mid_rst_frm_valid", 32'(frm_valid), 0);
    check("mid_rst_frm_last", 32'(frm_last), 0);
    check("mid_rst_busy", 32'(drain_busy), 0);
    check("mid_rst_err", 32'(err_count), 0);
    rx_ready    = 1'b0;
    clr_pending = 1'b0;
    next_rd     = 8'h00;
    mdl_buf.delete();
    sb.delete();
    err_exp = 0;
    step();
    step();
    clear_obs();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
`ifdef HDLC_RX_DRAIN_FCS_EN
    check("cfg_writes", n_writes, 1);
    check("cfg_write", 32'({last_waddr, last_wdata}), 32'({3'd2, 8'h20}));
`else
    check("cfg_writes", n_writes, 0);
`endif
    check("post_rst_reads", n_reads, 0);
    check("post_rst_busy", 32'(drain_busy), 0);
    check("post_rst_beats", n_beats, 0);
    run_frame(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
